// File: rtl/regdump_tracer.sv
// Register-file change tracer: detects per-register value changes on a flat dump bus
// and queues {index, value, cycle} events in a show-ahead FIFO with coalescing.
module regdump_tracer #(
   parameter int XLEN    = 32,
   parameter int NREG    = 32,
   parameter int DEPTH   = 8,
   parameter int CYC_W   = 16,
   parameter int SKIP_X0 = 1,
   localparam int IDX_W  = (NREG > 1) ? $clog2(NREG) : 1,
   localparam int PW     = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   clr,
   input  logic [NREG*XLEN-1:0]   reg_dump,
   output logic                   ev_valid,
   input  logic                   ev_ready,
   output logic [IDX_W-1:0]       ev_idx,
   output logic [XLEN-1:0]        ev_data,
   output logic [CYC_W-1:0]       ev_cycle,
   output logic [15:0]            coal_cnt,
   output logic                   fifo_full
);

   typedef enum logic {S_PRIME = 1'b0, S_RUN = 1'b1} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  w_run;

   logic [NREG*XLEN-1:0]  r_shadow;
   logic [NREG-1:0]       r_pending;
   logic [CYC_W-1:0]      r_cyc;
   logic [15:0]           r_coal;
   logic [PW:0]           r_wptr;
   logic [PW:0]           r_rptr;

   logic [IDX_W-1:0]      r_mem_idx  [DEPTH];
   logic [XLEN-1:0]       r_mem_data [DEPTH];
   logic [CYC_W-1:0]      r_mem_cyc  [DEPTH];

   logic [NREG-1:0]       w_chg;
   logic                  w_any;
   logic [IDX_W-1:0]      w_p;
   logic [XLEN-1:0]       w_pdata;
   logic                  w_empty;
   logic                  w_full;
   logic                  w_pop;
   logic                  w_push;
   logic [NREG-1:0]       w_pmask;
   logic                  w_coal_hit;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_PRIME;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_run       = 1'b0;
      if (clr) begin
         w_state_nxt = S_PRIME;
      end else begin
         case (r_state)
            S_PRIME: w_state_nxt = S_RUN;
            S_RUN:   w_run       = 1'b1;
            default: w_state_nxt = S_PRIME;
         endcase
      end
   end

   always_comb begin
      w_chg = '0;
      for (int i = 0; i < NREG; i++)
         w_chg[i] = en && (reg_dump[i*XLEN +: XLEN] != r_shadow[i*XLEN +: XLEN]);
      if (SKIP_X0 != 0) w_chg[0] = 1'b0;
   end

   // Descending scan so the last hit wins: the lowest pending index is selected.
   always_comb begin
      w_any   = 1'b0;
      w_p     = '0;
      w_pdata = '0;
      for (int i = NREG - 1; i >= 0; i--) begin
         if (r_pending[i]) begin
            w_any   = 1'b1;
            w_p     = IDX_W'(i);
            w_pdata = reg_dump[i*XLEN +: XLEN];
         end
      end
   end

   assign w_empty    = (r_wptr == r_rptr);
   assign w_full     = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
   assign w_pop      = !w_empty && ev_ready;
   // A full FIFO still accepts a push when the head is leaving in the same cycle.
   assign w_push     = w_run && w_any && (!w_full || w_pop);
   assign w_pmask    = w_push ? (NREG'(1) << w_p) : '0;
   assign w_coal_hit = w_run && (|(w_chg & r_pending & ~w_pmask));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_shadow  <= '0;
         r_pending <= '0;
         r_cyc     <= '0;
         r_coal    <= '0;
         r_wptr    <= '0;
         r_rptr    <= '0;
      end else if (clr) begin
         r_shadow  <= reg_dump;
         r_pending <= '0;
         r_cyc     <= '0;
         r_coal    <= '0;
         r_wptr    <= '0;
         r_rptr    <= '0;
      end else begin
         r_shadow <= reg_dump;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_run) begin
            r_pending <= (r_pending | w_chg) & ~w_pmask;
            r_cyc     <= r_cyc + 1'b1;
            if (w_coal_hit && (r_coal != 16'hFFFF)) r_coal <= r_coal + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_idx[r_wptr[PW-1:0]]  <= w_p;
         r_mem_data[r_wptr[PW-1:0]] <= w_pdata;
         r_mem_cyc[r_wptr[PW-1:0]]  <= r_cyc;
      end
   end

   // Head fields are forced to zero while empty so uninitialised storage never shows.
   assign ev_valid  = !w_empty;
   assign ev_idx    = w_empty ? '0 : r_mem_idx[r_rptr[PW-1:0]];
   assign ev_data   = w_empty ? '0 : r_mem_data[r_rptr[PW-1:0]];
   assign ev_cycle  = w_empty ? '0 : r_mem_cyc[r_rptr[PW-1:0]];
   assign coal_cnt  = r_coal;
   assign fifo_full = w_full;

endmodule

// File: tb/tb_regdump_tracer.sv
// Self-checking bench for regdump_tracer: directed table, hand sequences for
// back-pressure/enable/clear, then random traffic against a queue-based model.
module tb_regdump_tracer;
   localparam int XLEN  = 32;
   localparam int NREG  = 32;
   localparam int DEPTH = 8;
   localparam int CYC_W = 4;

   logic                  clk = 1'b0;
   logic                  rst = 1'b0;
   logic                  en = 1'b1;
   logic                  clr = 1'b0;
   logic [NREG*XLEN-1:0]  dump = '0;
   logic                  ev_valid;
   logic                  ev_ready = 1'b1;
   logic [4:0]            ev_idx;
   logic [XLEN-1:0]       ev_data;
   logic [CYC_W-1:0]      ev_cycle;
   logic [15:0]           coal_cnt;
   logic                  fifo_full;

   int total = 0;
   int bad   = 0;
   int edge_cnt = 0;
   int step_no = 0;

   regdump_tracer #(.XLEN(XLEN), .NREG(NREG), .DEPTH(DEPTH), .CYC_W(CYC_W), .SKIP_X0(1)) dut (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .reg_dump(dump),
      .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_idx(ev_idx), .ev_data(ev_data),
      .ev_cycle(ev_cycle), .coal_cnt(coal_cnt), .fifo_full(fifo_full)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0]       idx;
      logic [XLEN-1:0]  data;
      logic [CYC_W-1:0] cyc;
   } ev_t;

   ev_t             m_q[$];
   logic [XLEN-1:0] m_shadow [NREG];
   bit              m_pend   [NREG];
   bit              m_prime;
   int              m_cyc;
   int              m_coal;

   function automatic logic [XLEN-1:0] rd(int i);
      return dump[i*XLEN +: XLEN];
   endfunction

   task automatic wr(int i, logic [XLEN-1:0] v);
      dump[i*XLEN +: XLEN] = v;
   endtask

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (step %0d)", name, act, exp, step_no);
      end
   endtask

   task automatic model_step();
      bit pop, pushed;
      bit hit;
      int p;
      if (!rst) begin
         m_q.delete();
         foreach (m_pend[i]) begin m_pend[i] = 0; m_shadow[i] = '0; end
         m_prime = 1; m_cyc = 0; m_coal = 0;
      end else if (clr) begin
         m_q.delete();
         foreach (m_pend[i]) begin m_pend[i] = 0; m_shadow[i] = rd(i); end
         m_prime = 1; m_cyc = 0; m_coal = 0;
      end else begin
         pop = (m_q.size() > 0) && ev_ready;
         if (m_prime) begin
            if (pop) void'(m_q.pop_front());
            foreach (m_shadow[i]) m_shadow[i] = rd(i);
            m_prime = 0;
         end else begin
            p = -1;
            for (int i = NREG - 1; i >= 0; i--) if (m_pend[i]) p = i;
            pushed = (p >= 0) && ((m_q.size() < DEPTH) || pop);
            hit = 0;
            for (int i = 0; i < NREG; i++) begin
               bit c;
               c = en && (rd(i) != m_shadow[i]) && (i != 0);
               if (pushed && i == p) m_pend[i] = 0;
               else begin
                  if (c && m_pend[i]) hit = 1;
                  m_pend[i] = m_pend[i] | c;
               end
            end
            if (hit && m_coal < 16'hFFFF) m_coal++;
            if (pop) void'(m_q.pop_front());
            if (pushed) m_q.push_back('{idx: 5'(p), data: rd(p), cyc: CYC_W'(m_cyc)});
            foreach (m_shadow[i]) m_shadow[i] = rd(i);
            m_cyc = (m_cyc + 1) % (1 << CYC_W);
         end
      end
   endtask

   task automatic compare_model();
      logic [58:0] act, exp;
      act = {ev_valid, ev_idx, ev_data, ev_cycle, fifo_full, coal_cnt};
      if (m_q.size() > 0)
         exp = {1'b1, m_q[0].idx, m_q[0].data, m_q[0].cyc, (m_q.size() == DEPTH), 16'(m_coal)};
      else
         exp = {1'b0, 5'd0, 32'd0, 4'd0, 1'b0, 16'(m_coal)};
      chk("model", 64'(act), 64'(exp));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      model_step();
      edge_cnt++;
      step_no++;
      compare_model();
   endtask

   typedef struct packed {
      logic [3:0]             wen;
      logic [3:0][4:0]        wi;
      logic [3:0][XLEN-1:0]   wv;
      logic                   ev;
      logic [4:0]             eidx;
      logic [XLEN-1:0]        edata;
   } vec_t;

   function automatic vec_t mk(logic [3:0] wen, int i0, int i1, int i2, int i3,
                               logic [XLEN-1:0] v0, logic [XLEN-1:0] v1,
                               logic [XLEN-1:0] v2, logic [XLEN-1:0] v3,
                               logic ev, int eidx, logic [XLEN-1:0] edata);
      vec_t r;
      r.wen = wen;
      r.wi[0] = 5'(i0); r.wi[1] = 5'(i1); r.wi[2] = 5'(i2); r.wi[3] = 5'(i3);
      r.wv[0] = v0; r.wv[1] = v1; r.wv[2] = v2; r.wv[3] = v3;
      r.ev = ev; r.eidx = 5'(eidx); r.edata = edata;
      return r;
   endfunction

   initial begin
      vec_t tbl [9];
      int   got_idx [$];
      logic [XLEN-1:0] got_data [$];

      tbl[0] = mk(4'b0001, 3, 0, 0, 0, 32'h1234, 0, 0, 0, 1'b0, 0, 0);
      tbl[1] = mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 3, 32'h1234);
      tbl[2] = mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 0, 0);
      tbl[3] = mk(4'b1111, 1, 4, 9, 0, 32'hA1, 32'hA4, 32'hA9, 32'hDEAD, 1'b0, 0, 0);
      tbl[4] = mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 1, 32'hA1);
      tbl[5] = mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 4, 32'hA4);
      tbl[6] = mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 9, 32'hA9);
      tbl[7] = mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 0, 0);
      tbl[8] = mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 0, 0);

      // Reset with a non-zero register present; it must never be reported.
      wr(5, 32'd7);
      step();
      step();
      chk("rst_valid", 64'(ev_valid), 64'd0);
      chk("rst_full", 64'(fifo_full), 64'd0);
      chk("rst_coal", 64'(coal_cnt), 64'd0);
      chk("rst_idx", 64'(ev_idx), 64'd0);
      rst = 1'b1;
      edge_cnt = 0;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("prime_quiet", 64'(ev_valid), 64'd0);
      end

      // Single change and simultaneous changes, applied row by row.
      for (int r = 0; r < 9; r++) begin
         for (int w = 0; w < 4; w++) if (tbl[r].wen[w]) wr(int'(tbl[r].wi[w]), tbl[r].wv[w]);
         step();
         chk("tbl_valid", 64'(ev_valid), 64'(tbl[r].ev));
         if (tbl[r].ev) begin
            chk("tbl_idx", 64'(ev_idx), 64'(tbl[r].eidx));
            chk("tbl_data", 64'(ev_data), 64'(tbl[r].edata));
            chk("tbl_stamp", 64'(ev_cycle), 64'((edge_cnt - 2) & 15));
         end
      end

      // Back-pressure: ten changes into an 8-deep FIFO, then two more on x10.
      ev_ready = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         wr(i, 32'hB000_0000 + i);
         step();
         if (i == 9) chk("bp_full_at_8", 64'(fifo_full), 64'd1);
      end
      wr(10, 32'h2000_000A);
      step();
      wr(10, 32'h3000_000A);
      step();
      chk("bp_full", 64'(fifo_full), 64'd1);
      chk("bp_coal", 64'(coal_cnt), 64'd2);
      ev_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         if (ev_valid) begin
            got_idx.push_back(int'(ev_idx));
            got_data.push_back(ev_data);
         end
         step();
      end
      chk("bp_count", 64'(got_idx.size()), 64'd10);
      for (int k = 0; k < got_idx.size(); k++) chk("bp_order", 64'(got_idx[k]), 64'(k + 1));
      if (got_data.size() == 10) chk("bp_x10_final", 64'(got_data[9]), 64'h3000_000A);

      // Enable gating: a change made while disabled is absorbed silently.
      en = 1'b0;
      wr(2, 32'd5);
      step();
      chk("en_off_quiet", 64'(ev_valid), 64'd0);
      step();
      en = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("en_on_quiet", 64'(ev_valid), 64'd0);
      end
      wr(2, 32'd6);
      step();
      step();
      chk("en_valid", 64'(ev_valid), 64'd1);
      chk("en_idx", 64'(ev_idx), 64'd2);
      chk("en_data", 64'(ev_data), 64'd6);
      step();

      // Stamp wrap, then clear with three events queued.
      for (int k = 0; k < 20; k++) step();
      wr(7, 32'h77);
      step();
      step();
      chk("wrap_idx", 64'(ev_idx), 64'd7);
      chk("wrap_stamp", 64'(ev_cycle), 64'((edge_cnt - 2) & 15));
      step();
      ev_ready = 1'b0;
      wr(11, 32'h11); wr(12, 32'h12); wr(13, 32'h13);
      for (int k = 0; k < 4; k++) step();
      chk("clr_pre_valid", 64'(ev_valid), 64'd1);
      clr = 1'b1;
      ev_ready = 1'b1;
      step();
      clr = 1'b0;
      edge_cnt = 0;
      chk("clr_valid", 64'(ev_valid), 64'd0);
      chk("clr_coal", 64'(coal_cnt), 64'd0);
      step();
      wr(14, 32'hE);
      step();
      step();
      chk("clr_ev_idx", 64'(ev_idx), 64'd14);
      chk("clr_stamp", 64'(ev_cycle), 64'd1);
      step();

      // Random traffic with one asynchronous reset in the middle.
      for (int n = 0; n < 1500; n++) begin
         int nw;
         en = ($urandom_range(0, 7) != 0);
         ev_ready = ($urandom_range(0, 3) != 0);
         clr = ($urandom_range(0, 199) == 0);
         nw = $urandom_range(0, 3);
         for (int w = 0; w < nw; w++) wr($urandom_range(0, 15), 32'($urandom_range(0, 7)));
         step();
         if (n == 700) begin
            #3;
            rst = 1'b0;
            #1;
            chk("async_valid", 64'(ev_valid), 64'd0);
            chk("async_full", 64'(fifo_full), 64'd0);
            chk("async_coal", 64'(coal_cnt), 64'd0);
            step();
            rst = 1'b1;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/regdump_tracer.md
# regdump_tracer

Synthesizable register-file change tracer for the pipelined RISC-V core. It watches the flat `reg_dump` bus and records every architectural register that changed value. Each change becomes one event (register index, new value, cycle stamp) in an internal FIFO, drained through a valid/ready port. It replaces the simulation-only `$monitor` register printout with a generalised hardware trace: any XLEN, any register count, configurable depth, and change-only reporting with coalescing and back-pressure.

## Interface
- `XLEN`, 32, register width in bits
- `NREG`, 32, number of registers packed in `reg_dump`; register i occupies bits `[i*XLEN +: XLEN]`
- `DEPTH`, 8, event FIFO depth; power of two, ≥2
- `CYC_W`, 16, cycle-stamp width
- `SKIP_X0`, 1, when 1, register 0 never generates events
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-low (0 = reset)
- `en`  in  1  tracing enable
- `clr`  in  1  synchronous clear of trace state; priority over `en`
- `reg_dump`  in  NREG*XLEN  packed register file contents
- `ev_valid`  out  1  event available
- `ev_ready`  in  1  consumer accepts event
- `ev_idx`  out  clog2(NREG)  register index of head event
- `ev_data`  out  XLEN  new register value of head event
- `ev_cycle`  out  CYC_W  cycle stamp of head event
- `coal_cnt`  out  16  saturating count of coalesced changes
- `fifo_full`  out  1  FIFO holds DEPTH entries

## Operation
- State machine has two states:
  - PRIME: entered on reset or `clr`. `shadow <= reg_dump`. No pending bits are set. Next state is RUN.
  - RUN: runs the per-cycle steps below.
- Per RUN cycle, in this order:
  1. Detect: `chg[i] = (reg_dump[i] != shadow[i])`, masked by `en`. When `SKIP_X0=1`, `chg[0]` is forced to 0.
  2. Scan: if any `pending` bit is set and the FIFO is not full, select p = the lowest-index pending bit. Push {p, `reg_dump[p]`, `cyc`} and clear `pending[p]`.
  3. Update: `pending |= chg`, except that bit p is cleared when p is pushed in the same cycle. In that case the pushed value already reflects the change, so no duplicate event and no coalesce count.
  4. Coalesce: increment `coal_cnt` (saturating at 16'hFFFF) by 1 if any `chg[i]` hits an already-pending i ≠ p. This is at most +1 per cycle.
  5. `shadow <= reg_dump`. `cyc <= cyc + 1`; `cyc` wraps modulo 2^CYC_W and runs in RUN regardless of `en`.
- Rate: at most one push per cycle.
- FIFO full: scanning stalls and pending bits are held. The final value of every changed register is never lost; only intermediate values coalesce.
- `en`=0: no new pending bits. Scan and drain continue, and `shadow` keeps tracking, so re-enabling does not report changes that happened while disabled.
- Pop: occurs when `ev_valid && ev_ready`.
- FIFO is show-ahead: `ev_*` shows the head entry directly, and `ev_valid = !empty`.
- Push and pop in the same cycle on a full FIFO: both happen, and occupancy is unchanged.
- Push on an empty FIFO becomes visible on the next cycle.
- `clr`: empties the FIFO, zeroes `pending`, `coal_cnt` and `cyc`, then enters PRIME. An in-flight handshake in that cycle is discarded.

## Timing
- Reset (`rst`=0, asynchronous) sets:
  - state = PRIME, with `shadow`, `pending`, FIFO pointers, `cyc`, `coal_cnt` = 0
  - `ev_valid`=0, `ev_idx`=0, `ev_data`=0, `ev_cycle`=0, `coal_cnt`=0, `fifo_full`=0
- Reset release: edge 1 after release is PRIME. RUN starts at edge 2 with `cyc`=0.
- Latency: a change present before edge N (N in RUN, FIFO empty, no other pending) sets `pending` at edge N. It is pushed at edge N+1 with stamp `cyc`(N+1). `ev_valid` rises after edge N+1.
- Stamp: the stamp is the push cycle, not the detection cycle. The difference is one cycle when uncontended and larger under contention.
- Reset asserted mid-transfer: all state is lost immediately, and outputs take reset values without waiting for a clock.
- Outputs are registered or FIFO-head only. There is no combinational path from `ev_ready` to `ev_valid`.

## Test plan
- Reset and prime:
  - Stimulus: hold `rst`=0 for 2 cycles with `reg_dump` x5=7; release; `en`=1, `ev_ready`=1; no change.
  - Required: `ev_valid` stays 0. Non-zero values present at reset never generate events.
- Single change:
  - Stimulus: x3 goes 0→0x1234 one cycle.
  - Required: exactly one event {3, 0x1234}, visible 2 edges after the change.
  - Required: `ev_cycle` equals detection `cyc`+1.
- Simultaneous changes:
  - Stimulus: x1, x4 and x9 change in the same cycle.
  - Required: three events on consecutive cycles, in order idx 1, 4, 9.
  - Required: x0 written (`SKIP_X0`=1) produces no event.
- Back-pressure and coalesce:
  - Stimulus: `ev_ready`=0 with DEPTH=8; change x1..x10 once each, then change x10 twice more.
  - Required: `fifo_full`=1 after 8 pushes. x9 and x10 stay pending.
  - Required: `coal_cnt`=2.
  - Required: after `ev_ready`=1, 10 events are delivered, and x10 carries its final value.
- Enable gating:
  - Stimulus: `en`=0; change x2 to 5; `en`=1 with no further change.
  - Required: no event for x2.
  - Stimulus: later change x2 to 6.
  - Required: one event {2, 6}.
- Clear and wrap:
  - Stimulus: set `CYC_W`=4; run 20 cycles, then change x7.
  - Required: stamp wraps, i.e. value mod 16.
  - Stimulus: pulse `clr` with 3 events queued.
  - Required: `ev_valid`=0 next cycle, `coal_cnt`=0, `cyc` restarts at 0 after PRIME.
